// File: rtl/pipe_line_mul_param.sv
// Pipelined shift-add multiplier with per-operand signedness, valid/ready handshake and tag sideband.
// Optional PIPE_LINE_MUL_PERF_CNT_EN adds saturating transfer/stall counters (perf_ops, perf_stall).
`timescale 1ns/1ps
module pipe_line_mul_param #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 4,
    parameter int TAG_W  = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    input  logic               a_signed,
    input  logic               b_signed,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] result,
    output logic [TAG_W-1:0]   out_tag
`ifdef PIPE_LINE_MUL_PERF_CNT_EN
    ,
    output logic [31:0]        perf_ops,
    output logic [31:0]        perf_stall
`endif
);

    localparam int PW  = 2 * WIDTH;
    localparam int BPS = (STAGES > 0) ? WIDTH / STAGES : 1;

    if (STAGES < 1 || STAGES > WIDTH || (WIDTH % BPS) != 0 || BPS * STAGES != WIDTH) begin : g_param_check
        $error("pipe_line_mul_param: need 1 <= STAGES <= WIDTH and WIDTH %% STAGES == 0");
    end

    // Sum of the partial products for one slice of multiplier bits, modulo 2^PW.
    // For a signed multiplier the MSB carries weight -2^(WIDTH-1), so its term is subtracted.
    function automatic logic [PW-1:0] chunk_sum(input logic [PW-1:0] a_ext,
                                                input logic [BPS-1:0] bits,
                                                input int             base,
                                                input logic           b_sgn);
        logic [PW-1:0] acc;
        acc = '0;
        for (int i = 0; i < BPS; i++) begin
            if (bits[i]) begin
                if (b_sgn && (base + i == WIDTH - 1))
                    acc = acc - (a_ext << (base + i));
                else
                    acc = acc + (a_ext << (base + i));
            end
        end
        return acc;
    endfunction

    logic [STAGES-1:0] vld_p;
    logic [STAGES-1:0] load;
    logic [PW-1:0]     a_p   [STAGES];
    logic [WIDTH-1:0]  b_p   [STAGES];
    logic              bs_p  [STAGES];
    logic [PW-1:0]     sum_p [STAGES];
    logic [TAG_W-1:0]  tag_p [STAGES];
    logic [PW-1:0]     a_in_ext;

    assign a_in_ext = {{WIDTH{a_signed & multiplicand[WIDTH-1]}}, multiplicand};

    // A stage may load when it is empty or its occupant moves on this edge; empty slots absorb bubbles.
    always_comb begin : ready_chain
        logic chain;
        load  = '0;
        chain = !vld_p[STAGES-1] | out_ready;
        load[STAGES-1] = chain;
        for (int k = STAGES - 2; k >= 0; k--) begin
            chain   = !vld_p[k] | chain;
            load[k] = chain;
        end
    end

    assign in_ready = load[0];

    // Stage boundary: control path (valid bits) with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p <= '0;
        end else begin
            if (load[0])
                vld_p[0] <= in_valid;
            for (int k = 1; k < STAGES; k++) begin
                if (load[k])
                    vld_p[k] <= vld_p[k-1];
            end
        end
    end

    // Stage boundary: datapath; stage k folds in multiplier bits [k*BPS +: BPS] as it loads.
    always_ff @(posedge clk) begin
        if (load[0]) begin
            a_p[0]   <= a_in_ext;
            b_p[0]   <= multiplier;
            bs_p[0]  <= b_signed;
            tag_p[0] <= in_tag;
            sum_p[0] <= chunk_sum(a_in_ext, multiplier[BPS-1:0], 0, b_signed);
        end
        for (int k = 1; k < STAGES; k++) begin
            if (load[k]) begin
                a_p[k]   <= a_p[k-1];
                b_p[k]   <= b_p[k-1];
                bs_p[k]  <= bs_p[k-1];
                tag_p[k] <= tag_p[k-1];
                sum_p[k] <= sum_p[k-1] + chunk_sum(a_p[k-1], b_p[k-1][k*BPS +: BPS], k * BPS, bs_p[k-1]);
            end
        end
    end

    // The last stage's operand copies are never consumed.
    logic unused_tail;
    assign unused_tail = ^{a_p[STAGES-1], b_p[STAGES-1], bs_p[STAGES-1]};

    // Data registers are not reset, so the outputs are masked to zero while the last stage is empty.
    assign out_valid = vld_p[STAGES-1];
    assign result    = vld_p[STAGES-1] ? sum_p[STAGES-1] : '0;
    assign out_tag   = vld_p[STAGES-1] ? tag_p[STAGES-1] : '0;

`ifdef PIPE_LINE_MUL_PERF_CNT_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_ops   <= '0;
            perf_stall <= '0;
        end else begin
            if (out_valid && out_ready)
                perf_ops <= sat_inc(perf_ops);
            if (out_valid && !out_ready)
                perf_stall <= sat_inc(perf_stall);
        end
    end
`endif

endmodule

// File: tb/tb_pipe_line_mul_param.sv
// Scoreboard bench for pipe_line_mul_param: directed vectors, backpressure, bubbles, reset, optional counters.
`timescale 1ns/1ps
module tb_pipe_line_mul_param;
    localparam int WIDTH  = 8;
    localparam int STAGES = 4;
    localparam int TAG_W  = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [WIDTH-1:0]  multiplicand = '0;
    logic [WIDTH-1:0]  multiplier = '0;
    logic              a_signed = 1'b0;
    logic              b_signed = 1'b0;
    logic [TAG_W-1:0]  in_tag = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [2*WIDTH-1:0] result;
    logic [TAG_W-1:0]  out_tag;
`ifdef PIPE_LINE_MUL_PERF_CNT_EN
    logic [31:0]       perf_ops;
    logic [31:0]       perf_stall;
`endif

    pipe_line_mul_param #(.WIDTH(WIDTH), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .a_signed     (a_signed),
        .b_signed     (b_signed),
        .in_tag       (in_tag),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .result       (result),
        .out_tag      (out_tag)
`ifdef PIPE_LINE_MUL_PERF_CNT_EN
        ,
        .perf_ops     (perf_ops),
        .perf_stall   (perf_stall)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [TAG_W-1:0]   tag;
        logic [2*WIDTH-1:0] prod;
        int                 acc;
        bit                 lat;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    bit   rand_ordy = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    function automatic logic [15:0] ref_mul(input logic [7:0] a, input logic [7:0] b,
                                            input logic as_, input logic bs_);
        logic signed [16:0] ea;
        logic signed [16:0] eb;
        logic signed [33:0] p;
        ea = {{9{as_ & a[7]}}, a};
        eb = {{9{bs_ & b[7]}}, b};
        p  = ea * eb;
        return p[15:0];
    endfunction

    // Called with inputs driven just after a rising edge; returns just after the accepting edge.
    task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic as_, input logic bs_,
                         input logic [3:0] tg, input logic [15:0] req, input bit lat);
        exp_t e;
        int   n;
        bit   done;
        n = 0;
        done = 1'b0;
        multiplicand = a;
        multiplier   = b;
        a_signed     = as_;
        b_signed     = bs_;
        in_tag       = tg;
        in_valid     = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                e.tag  = tg;
                e.prod = req;
                e.acc  = cyc;
                e.lat  = lat;
                sbq.push_back(e);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
            n++;
            if (!done && n > 200) begin
                chk("issue_timeout", {31'b0, in_ready}, 32'd1);
                done = 1'b1;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (sbq.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (sbq.size() != 0)
            chk("drain_timeout", sbq.size(), 32'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Monitor: an output transfer happens at the next rising edge when valid and ready are both high here.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_output", {31'b0, out_valid}, 32'd0);
                end else begin
                    e = sbq.pop_front();
                    chk("out_tag", {28'b0, out_tag}, {28'b0, e.tag});
                    chk("product", {16'b0, result}, {16'b0, e.prod});
                    if (e.lat)
                        chk("latency", cyc - e.acc, STAGES);
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ordy)
                out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual_time=%0t required_limit=1000000", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] ra;
        logic [7:0] rb;
        logic       ras;
        logic       rbs;

        // Reset state
        #12;
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_result", {16'b0, result}, 32'd0);
        chk("rst_out_tag", {28'b0, out_tag}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_out_valid_after", {31'b0, out_valid}, 32'd0);
        @(posedge clk);
        #1;

        // Signed x signed stream, back-to-back
        issue(8'd4,   8'd3,   1'b1, 1'b1, 4'd0, 16'h000C, 1'b1);
        issue(8'hFC,  8'd3,   1'b1, 1'b1, 4'd1, 16'hFFF4, 1'b1);
        issue(8'd123, 8'hFA,  1'b1, 1'b1, 4'd2, 16'hFD1E, 1'b1);
        issue(8'h80,  8'd1,   1'b1, 1'b1, 4'd3, 16'hFF80, 1'b1);
        drain(50);

        // Signedness modes and zero operand
        issue(8'hFF, 8'hFF, 1'b0, 1'b0, 4'd4, 16'hFE01, 1'b1);
        issue(8'hFF, 8'hFF, 1'b1, 1'b0, 4'd5, 16'hFF01, 1'b1);
        issue(8'hFF, 8'hFF, 1'b1, 1'b1, 4'd6, 16'h0001, 1'b1);
        issue(8'h00, 8'h03, 1'b1, 1'b1, 4'd7, 16'h0000, 1'b1);
        drain(50);

        // Backpressure: four ops fill the pipe, two more wait for out_ready
        out_ready = 1'b0;
        issue(8'd2,   8'd3,   1'b0, 1'b0, 4'd8,  16'h0006, 1'b0);
        issue(8'd5,   8'd5,   1'b0, 1'b0, 4'd9,  16'h0019, 1'b0);
        issue(8'd16,  8'd16,  1'b0, 1'b0, 4'd10, 16'h0100, 1'b0);
        issue(8'd200, 8'd2,   1'b0, 1'b0, 4'd11, 16'h0190, 1'b0);
        @(negedge clk);
        chk("bp_in_ready_low", {31'b0, in_ready}, 32'd0);
        chk("bp_out_valid", {31'b0, out_valid}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_result_hold", {16'b0, result}, 32'h0006);
            chk("bp_tag_hold", {28'b0, out_tag}, 32'd8);
        end
        @(posedge clk);
        #1;
        fork
            begin
                issue(8'd255, 8'd1,   1'b0, 1'b0, 4'd12, 16'h00FF, 1'b0);
                issue(8'd100, 8'd100, 1'b0, 1'b0, 4'd13, 16'h2710, 1'b0);
            end
            begin
                repeat (6) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain(50);

        // Bubbles with random backpressure
        rand_ordy = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            ra  = 8'($urandom);
            rb  = 8'($urandom);
            ras = 1'($urandom_range(0, 1));
            rbs = 1'($urandom_range(0, 1));
            issue(ra, rb, ras, rbs, 4'(i), ref_mul(ra, rb, ras, rbs), 1'b0);
            multiplicand = 8'($urandom);
            multiplier   = 8'($urandom);
            @(posedge clk);
            #1;
        end
        rand_ordy = 1'b0;
        out_ready = 1'b1;
        drain(200);

        // Reset with three ops in flight
        out_ready = 1'b0;
        issue(8'd9,  8'd9,  1'b0, 1'b0, 4'd1, 16'h0051, 1'b0);
        issue(8'd7,  8'd7,  1'b0, 1'b0, 4'd2, 16'h0031, 1'b0);
        issue(8'd3,  8'd3,  1'b0, 1'b0, 4'd3, 16'h0009, 1'b0);
        @(posedge clk);
        #3;
        chk("pre_reset_out_valid", {31'b0, out_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("async_rst_result", {16'b0, result}, 32'd0);
        chk("async_rst_out_tag", {28'b0, out_tag}, 32'd0);
        sbq.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("post_reset_no_valid", {31'b0, out_valid}, 32'd0);
        end
        @(posedge clk);
        #1;
        issue(8'd5, 8'd6, 1'b0, 1'b0, 4'hA, 16'h001E, 1'b1);
        drain(50);

`ifdef PIPE_LINE_MUL_PERF_CNT_EN
        // Counters: 10 transfers, 7 stalled cycles
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        issue(8'd1, 8'd1, 1'b0, 1'b0, 4'd0, 16'h0001, 1'b0);
        begin
            int n;
            n = 0;
            @(negedge clk);
            while (!out_valid && n < 20) begin
                @(negedge clk);
                n++;
            end
            chk("perf_first_valid", {31'b0, out_valid}, 32'd1);
        end
        repeat (7) @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int i = 1; i < 10; i++)
            issue(8'(i), 8'd2, 1'b0, 1'b0, 4'(i), 16'(2 * i), 1'b0);
        drain(50);
        chk("perf_ops", perf_ops, 32'd10);
        chk("perf_stall", perf_stall, 32'd7);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pipe_line_mul_param.md
Name: pipe_line_mul_param

Overview:
Parametrised, fully pipelined shift-add multiplier; successor to the fixed 8-bit start/ready pipelined multiplier in mini_core_accel.
- Generic operand width and stage count.
- Per-operand signed/unsigned selection (covers the RISC-V MUL/MULH/MULHSU/MULHU needs).
- Valid/ready handshake on both sides, with backpressure and a sideband tag.
- Sits between the accelerator issue logic and its writeback arbiter.

Parameters:
WIDTH, 8, operand width in bits; result is 2*WIDTH.
STAGES, 4, pipeline depth; 1 <= STAGES <= WIDTH, WIDTH % STAGES == 0 (elaboration $error otherwise).
TAG_W, 4, width of the opaque tag carried alongside each operation.

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operation presented
in_ready  out  1  block accepts operation this cycle
multiplicand  in  WIDTH  operand A
multiplier  in  WIDTH  operand B
a_signed  in  1  1: A is two's complement, 0: unsigned
b_signed  in  1  1: B is two's complement, 0: unsigned
in_tag  in  TAG_W  sideband id, returned unchanged
out_valid  out  1  result available
out_ready  in  1  consumer accepts result
result  out  2*WIDTH  full-width product
out_tag  out  TAG_W  tag of the operation in result

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - All stage valid bits are 0, so out_valid=0.
  - result=0 and out_tag=0.
  - in_ready=1 from the first edge after reset release.
- Transfer rules:
  - An input transfer occurs when in_valid & in_ready at a rising edge.
  - An output transfer occurs when out_valid & out_ready.
- Stage k (k=0..STAGES-1) holds: valid, A sign-extended to 2*WIDTH per a_signed, remaining multiplier bits, partial sum (2*WIDTH), tag.
- Stage k adds the partial products for multiplier bits [k*WIDTH/STAGES +: WIDTH/STAGES].
- Signed B: the partial product for bit WIDTH-1 is subtracted rather than added (weight -2^(WIDTH-1)).
- All arithmetic is modulo 2^(2*WIDTH), so the result is exact for every signedness combination.
- Stage advance: stage k loads when (stage k empty) | (stage k+1 loads) | (k is last & out_ready).
  - Bubbles collapse.
  - in_ready equals the stage-0 load condition, combinational from out_ready via the ready chain.
- Latency:
  - result/out_valid appear STAGES edges after the accepting edge when unstalled.
  - Throughput is 1 op/cycle.
- Backpressure:
  - With out_ready=0 and out_valid=1, result and out_tag hold stable.
  - Up to STAGES ops are buffered; in_ready then drops to 0.
  - Nothing is dropped or duplicated.
- Ordering is strictly FIFO, and tags are returned in acceptance order.
- Simultaneous output transfer and full pipe: in_ready=1 in that cycle (pass-through).
- Zero operand: no special case; the result is 0 at normal latency.
- Reset mid-operation: all in-flight ops are discarded, with no spurious out_valid after release.
- in_valid=0 while in_ready=1: a bubble is inserted; operand inputs are don't-care.

Optional Feature:
Macro PIPE_LINE_MUL_PERF_CNT_EN.
- Defined: adds outputs perf_ops (32) and perf_stall (32).
  - perf_ops counts output transfers.
  - perf_stall counts cycles with out_valid & !out_ready.
  - Both are reset to 0 and saturate at all-ones.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Settings for all scenarios: WIDTH=8, STAGES=4, out_ready=1.
- Signed×signed stream, one op per cycle, tags 0..3:
  - 4×3 -> 0x000C; -4×3 -> 0xFFF4; 123×-6 -> 0xFD1E; -128×1 -> 0xFF80.
  - Each result 4 edges after its acceptance, tags in order.
- Signedness modes:
  - A=0xFF, B=0xFF with a_signed=b_signed=0 -> 0xFE01.
  - Same operands with a_signed=1, b_signed=0 -> 0xFF01.
  - Same operands with both signed -> 0x0001.
  - 0×3 -> 0x0000.
- Backpressure:
  - Hold out_ready=0 and issue 6 ops; in_ready falls after the 4th acceptance, and result stays stable.
  - Release out_ready; all 6 results are delivered in order with no loss.
- Bubbles:
  - Alternate in_valid 1/0 with out_ready toggling on a pseudo-random pattern.
  - Scoreboard matches each tag/product against a reference model across 1000 random signed/unsigned ops.
- Reset mid-operation:
  - Assert rst_n=0 asynchronously with 3 ops in flight.
  - Outputs go to 0 immediately, out_valid stays 0 after release, and the next op (5×6) returns 0x001E.
- PIPE_LINE_MUL_PERF_CNT_EN:
  - 10 ops with 7 stall cycles -> perf_ops=10 and perf_stall=7.
